// File: rtl/adc_sequencer.sv
// Conversion scheduler for the 10-bit serial ADC interface: periodic or one-shot requests,
// result capture and optional 2^AVG_LOG2 averaging (compiled in with `define ADC_SEQ_AVG_EN).
module adc_sequencer #(
  parameter int unsigned PERIOD   = 1000,
  parameter int unsigned AVG_LOG2 = 2,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       trig,
  input  logic       clear_err,
  output logic       adc_start,
  input  logic       adc_done,
  input  logic [9:0] adc_dout,
  output logic       busy,
  output logic [9:0] sample,
  output logic       sample_valid,
  output logic       timeout_err,
  output logic       overrun
);

  localparam int unsigned DW = 10;
  localparam int unsigned PW = $clog2(PERIOD);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  if (PERIOD < 32) begin : g_period_chk
    $error("adc_sequencer: PERIOD must be at least 32");
  end
  if (AVG_LOG2 > 6) begin : g_avg_chk
    $error("adc_sequencer: AVG_LOG2 must be in 0..6");
  end
  if (TIMEOUT < 1) begin : g_timeout_chk
    $error("adc_sequencer: TIMEOUT must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_CONV    = 3'd2,
    S_CAPTURE = 3'd3,
    S_EMIT    = 3'd4
  } state_e;

  state_e        state_q;
  logic [PW-1:0] period_q, period_d;
  logic [TW-1:0] timer_q;
  logic [DW-1:0] sample_q;
  logic          pending_q;
  logic          adc_start_q;
  logic          busy_q;
  logic          sample_valid_q;
  logic          timeout_err_q;
  logic          overrun_q;
  logic          tick_c;
  logic          req_c;
  logic          start_c;
  logic          timeout_c;

`ifdef ADC_SEQ_AVG_EN
  localparam int unsigned AW = DW + AVG_LOG2;
  localparam int unsigned CW = AVG_LOG2 + 1;

  logic [AW-1:0] acc_q, acc_sum_c;
  logic [CW-1:0] count_q, count_inc_c;
  logic          last_c;

  assign acc_sum_c   = acc_q + AW'(adc_dout);
  assign count_inc_c = count_q + CW'(1);
  assign last_c      = (count_inc_c == CW'(1 << AVG_LOG2));
`endif

  // Period counter: free-runs while enabled, held at zero otherwise; tick on wrap.
  always_comb begin
    tick_c   = 1'b0;
    period_d = period_q;
    if (!enable) begin
      period_d = '0;
    end else if (period_q == PW'(PERIOD - 1)) begin
      period_d = '0;
      tick_c   = 1'b1;
    end else begin
      period_d = period_q + PW'(1);
    end
  end

  assign req_c     = tick_c | (trig & ~enable);
  assign start_c   = (state_q == S_IDLE) && (pending_q || req_c) && adc_done;
  assign timeout_c = (timer_q == TW'(TIMEOUT - 1));

  // A request arriving in the launch cycle is consumed directly, giving one cycle tick-to-start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_q  <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      period_q <= period_d;
      if (start_c) begin
        pending_q <= 1'b0;
      end else if (req_c && !pending_q) begin
        pending_q <= 1'b1;
      end
      if (clear_err) begin
        overrun_q <= 1'b0;
      end
      if (req_c && pending_q) begin
        overrun_q <= 1'b1;
      end
    end
  end

  // Handshake state machine with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      timer_q        <= '0;
      adc_start_q    <= 1'b0;
      busy_q         <= 1'b0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      timeout_err_q  <= 1'b0;
`ifdef ADC_SEQ_AVG_EN
      acc_q          <= '0;
      count_q        <= '0;
`endif
    end else begin
      sample_valid_q <= 1'b0;
      if (clear_err) begin
        timeout_err_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (start_c) begin
            state_q     <= S_REQ;
            adc_start_q <= 1'b1;
            busy_q      <= 1'b1;
            timer_q     <= '0;
          end
        end
        S_REQ: begin
          if (!adc_done) begin
            state_q     <= S_CONV;
            adc_start_q <= 1'b0;
            timer_q     <= '0;
          end else if (timeout_c) begin
            state_q       <= S_IDLE;
            adc_start_q   <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b1;
`ifdef ADC_SEQ_AVG_EN
            acc_q         <= '0;
            count_q       <= '0;
`endif
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        S_CONV: begin
          if (adc_done) begin
            state_q <= S_CAPTURE;
          end else if (timeout_c) begin
            state_q       <= S_IDLE;
            adc_start_q   <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b1;
`ifdef ADC_SEQ_AVG_EN
            acc_q         <= '0;
            count_q       <= '0;
`endif
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        S_CAPTURE: begin
`ifdef ADC_SEQ_AVG_EN
          acc_q   <= acc_sum_c;
          count_q <= count_inc_c;
          if (last_c) begin
            state_q        <= S_EMIT;
            sample_q       <= acc_sum_c[AW-1:AVG_LOG2];
            sample_valid_q <= 1'b1;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
`else
          state_q        <= S_EMIT;
          sample_q       <= adc_dout;
          sample_valid_q <= 1'b1;
`endif
        end
        S_EMIT: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
`ifdef ADC_SEQ_AVG_EN
          acc_q   <= '0;
          count_q <= '0;
`endif
        end
        default: begin
          state_q     <= S_IDLE;
          adc_start_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign adc_start    = adc_start_q;
  assign busy         = busy_q;
  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign timeout_err  = timeout_err_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_adc_sequencer.sv
// Directed bench for adc_sequencer (PERIOD=100, AVG_LOG2=2, TIMEOUT=64) with an 18-cycle ADC model.
module tb_adc_sequencer;

`ifdef ADC_SEQ_AVG_EN
  localparam bit AVG = 1'b1;
`else
  localparam bit AVG = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       trig;
  logic       clear_err;
  logic       adc_start;
  logic       adc_done;
  logic [9:0] adc_dout;
  logic       busy;
  logic [9:0] sample;
  logic       sample_valid;
  logic       timeout_err;
  logic       overrun;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  adc_sequencer #(.PERIOD(100), .AVG_LOG2(2), .TIMEOUT(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .trig         (trig),
    .clear_err    (clear_err),
    .adc_start    (adc_start),
    .adc_done     (adc_done),
    .adc_dout     (adc_dout),
    .busy         (busy),
    .sample       (sample),
    .sample_valid (sample_valid),
    .timeout_err  (timeout_err),
    .overrun      (overrun)
  );

  // ADC interface model: drops done one edge after seeing start, frame of 18 cycles,
  // then presents the next table entry and returns idle.
  logic       stuck;
  logic [9:0] tab [0:3];
  logic [1:0] vi;
  int         conv_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      adc_done <= 1'b1;
      adc_dout <= '0;
      vi       <= '0;
      conv_cnt <= 0;
    end else if (conv_cnt != 0) begin
      conv_cnt <= conv_cnt - 1;
      if (conv_cnt == 1) begin
        adc_done <= 1'b1;
        adc_dout <= tab[vi];
        vi       <= vi + 2'd1;
      end
    end else if (adc_start && adc_done && !stuck) begin
      adc_done <= 1'b0;
      conv_cnt <= 18;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One trig-launched conversion, followed until busy falls (bounded).
  task automatic conv_once(output int nval, output logic [9:0] last, output int start_cyc);
    int c;
    bit seen;
    nval      = 0;
    last      = '0;
    start_cyc = 0;
    seen      = 1'b0;
    trig = 1'b1;
    step();
    trig = 1'b0;
    for (c = 0; c < 200; c++) begin
      if (adc_start) start_cyc++;
      if (sample_valid) begin
        nval++;
        last = sample;
      end
      if (busy) seen = 1'b1;
      else if (seen) break;
      step();
    end
    check("conv_completes", 32'(c < 200), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_adc_start"}, 32'(adc_start), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_sample"}, 32'(sample), 32'd0);
    check({tag, "_sample_valid"}, 32'(sample_valid), 32'd0);
    check({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    check({tag, "_overrun"}, 32'(overrun), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nval, tot, st, first_start, first_v, second_v, rises, high, start_hi;
    int brises, gap, orise;
    logic [9:0] last, l1;
    logic pv, pb, ps;

    rst = 1'b0; enable = 1'b0; trig = 1'b0; clear_err = 1'b0; stuck = 1'b0;
    tab[0] = 10'd100; tab[1] = 10'd101; tab[2] = 10'd102; tab[3] = 10'd105;
    #1 rst = 1'b1;
    repeat (3) step();
    check_all_zero("reset");
    rst = 1'b0;
    step();

    // Periodic ticks: first start 100 cycles after enable, conversions every 100 cycles.
    enable = 1'b1;
    first_start = -1; first_v = -1; second_v = -1; nval = 0; rises = 0; high = 0;
    start_hi = 0; last = '0; pv = 1'b0;
    for (int c = 1; c <= 430; c++) begin
      step();
      if (adc_start && first_start < 0) first_start = c;
      if (adc_start) start_hi++;
      if (sample_valid) begin
        high++;
        last = sample;
        if (!pv) begin
          rises++;
          if (first_v < 0) first_v = c;
          else if (second_v < 0) second_v = c;
        end
      end
      pv = sample_valid;
    end
    enable = 1'b0;
    check("tick_to_start", 32'(first_start), 32'd100);
    check("start_high_cycles", 32'(start_hi), 32'd8);
    check("periodic_valid_count", 32'(rises), AVG ? 32'd1 : 32'd4);
    check("valid_one_cycle", 32'(high), 32'(rises));
    check("first_valid_cycle", 32'(first_v), AVG ? 32'd421 : 32'd121);
    check("periodic_sample", 32'(last), AVG ? 32'd102 : 32'd105);
    if (!AVG) check("valid_interval", 32'(second_v - first_v), 32'd100);
    step();
    check("idle_after_periodic", 32'(busy), 32'd0);

    // One conversion leaves a partial average, then a stuck ADC times out and discards it.
    conv_once(nval, last, st);
    check("trig_start_cycles", 32'(st), 32'd2);
    check("partial_valid_count", 32'(nval), AVG ? 32'd0 : 32'd1);
    stuck = 1'b1;
    conv_once(nval, last, st);
    check("timeout_start_cycles", 32'(st), 32'd64);
    check("timeout_no_valid", 32'(nval), 32'd0);
    check("timeout_err_set", 32'(timeout_err), 32'd1);
    check("timeout_idle", 32'(busy), 32'd0);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    check("timeout_err_cleared", 32'(timeout_err), 32'd0);
    stuck = 1'b0;
    tab[0] = 10'd200; tab[1] = 10'd300; tab[2] = 10'd400; tab[3] = 10'd500;
    tot = 0; l1 = '0;
    for (int k = 0; k < 4; k++) begin
      conv_once(nval, last, st);
      tot += nval;
      if (nval != 0) l1 = last;
    end
    check("post_timeout_valid_count", 32'(tot), AVG ? 32'd1 : 32'd4);
    check("post_timeout_sample", 32'(l1), AVG ? 32'd350 : 32'd200);

    // Trigs while busy: second queued, third (with clear_err) sets overrun.
    brises = 0; gap = 0; orise = 0; nval = 0; last = '0; pb = 1'b0; ps = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      trig      = (c == 1) || (c == 6) || (c == 11);
      clear_err = (c == 11);
      step();
      trig = 1'b0; clear_err = 1'b0;
      if (c == 10) check("no_overrun_before_third", 32'(overrun), 32'd0);
      if (c == 11) check("overrun_set_beats_clear", 32'(overrun), 32'd1);
      if (busy && !pb) brises++;
      if (!busy && brises == 1) gap++;
      if (adc_start && !ps) orise++;
      if (sample_valid) begin
        nval++;
        last = sample;
      end
      pb = busy;
      ps = adc_start;
    end
    check("queued_start_count", 32'(orise), 32'd2);
    check("queued_busy_runs", 32'(brises), 32'd2);
    check("queued_idle_gap", 32'(gap), 32'd1);
    check("queued_valid_count", 32'(nval), AVG ? 32'd0 : 32'd2);
    check("queued_sample", 32'(last), AVG ? 32'd0 : 32'd400);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    check("overrun_cleared", 32'(overrun), 32'd0);

    // Asynchronous reset during CONV.
    trig = 1'b1;
    step();
    trig = 1'b0;
    repeat (5) step();
    check("busy_before_reset", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1 check_all_zero("async_reset");
    step();
    rst = 1'b0;
    nval = 0; tot = 0;
    for (int c = 0; c < 150; c++) begin
      step();
      if (sample_valid) nval++;
      if (busy) tot++;
    end
    check("no_valid_after_reset", 32'(nval), 32'd0);
    check("no_busy_after_reset", 32'(tot), 32'd0);

    // Full-scale results: accumulator must hold 4 x 0x3FF without overflow.
    tab[0] = 10'h3FF; tab[1] = 10'h3FF; tab[2] = 10'h3FF; tab[3] = 10'h3FF;
    tot = 0; l1 = '0;
    for (int k = 0; k < 4; k++) begin
      conv_once(nval, last, st);
      tot += nval;
      if (nval != 0) l1 = last;
    end
    check("fullscale_valid_count", 32'(tot), AVG ? 32'd1 : 32'd4);
    check("fullscale_sample", 32'(l1), 32'h3FF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
